// File: rtl/writeback_ctrl.sv
// Writeback buffer: 2-entry in-order FIFO feeding the register-file write/swap port, with optional forwarding (macro WB_FORWARD_EN).
// Latency: an entry pushed at edge N drives RegWrt in cycle N+1 and retires at edge N+1 unless hold is set.
// Backpressure: in_ready drops when both entries are occupied (no push-through); hold stalls the head in place.
module writeback_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_swp,
   input  logic [3:0]  in_dst,
   input  logic [3:0]  in_src,
   input  logic [15:0] in_dataA,
   input  logic [15:0] in_dataB,
   input  logic        hold,
   output logic        RegWrt,
   output logic        RegSwp,
   output logic [3:0]  wrtRegOp1,
   output logic [3:0]  swpReg1,
   output logic [3:0]  swpReg2,
   output logic [15:0] wrtDataOp1,
   output logic [15:0] wrtDataOp2,
   input  logic [3:0]  fwd_addr1,
   input  logic [3:0]  fwd_addr2,
   output logic        fwd_hit1,
   output logic        fwd_hit2,
   output logic [15:0] fwd_data1,
   output logic [15:0] fwd_data2,
   output logic [1:0]  pending
);

   typedef struct packed {
      logic        swp;
      logic [3:0]  dst;
      logic [3:0]  src;
      logic [15:0] dataA;
      logic [15:0] dataB;
   } wbEntry_t;

   // headEnt is always the oldest entry; tailEnt is only meaningful when count==2.
   wbEntry_t   headEnt;
   wbEntry_t   tailEnt;
   wbEntry_t   newEnt;
   logic [1:0] count;
   logic       push;
   logic       pop;
   logic       notEmpty;

   assign newEnt   = '{swp: in_swp, dst: in_dst, src: in_src, dataA: in_dataA, dataB: in_dataB};
   assign notEmpty = (count != 2'd0);

   // rst gates in_ready so the block advertises nothing while reset is asserted.
   assign in_ready = rst & (count != 2'd2);
   assign push     = in_valid & in_ready;
   assign RegWrt   = notEmpty & ~hold;
   assign pop      = RegWrt;
   assign RegSwp   = headEnt.swp & RegWrt;
   assign pending  = count;

   assign wrtRegOp1  = notEmpty ? headEnt.dst   : 4'h0;
   assign swpReg1    = notEmpty ? headEnt.dst   : 4'h0;
   assign swpReg2    = notEmpty ? headEnt.src   : 4'h0;
   assign wrtDataOp1 = notEmpty ? headEnt.dataA : 16'h0000;
   assign wrtDataOp2 = notEmpty ? headEnt.dataB : 16'h0000;

   // FIFO storage: shift tail into head on pop; a push lands in the first free slot.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         headEnt <= '0;
         tailEnt <= '0;
         count   <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) headEnt <= newEnt;
               else               tailEnt <= newEnt;
               count <= count + 2'd1;
            end
            2'b01: begin
               headEnt <= tailEnt;
               tailEnt <= '0;
               count   <= count - 2'd1;
            end
            2'b11: begin
               // push implies count<2 and pop implies count>0, so count==1:
               // the head retires and the new entry becomes the head.
               headEnt <= newEnt;
            end
            default: begin
            end
         endcase
      end
   end

`ifdef WB_FORWARD_EN
   // Returns {hit, data} for one stored entry; a swap's dst match wins over src.
   function automatic logic [16:0] matchEntry(input wbEntry_t e, input logic [3:0] a);
      logic [16:0] r;
      r = '0;
      if (e.swp) begin
         if (e.dst == a)      r = {1'b1, e.dataB};
         else if (e.src == a) r = {1'b1, e.dataA};
      end else if (e.dst == a) begin
         r = {1'b1, e.dataA};
      end
      return r;
   endfunction

   logic [16:0] fwdRes1;
   logic [16:0] fwdRes2;

   // Forwarding lookup over stored entries only; the youngest (tail) wins.
   always_comb begin
      fwdRes1 = '0;
      fwdRes2 = '0;
      if (count == 2'd2) begin
         fwdRes1 = matchEntry(tailEnt, fwd_addr1);
         fwdRes2 = matchEntry(tailEnt, fwd_addr2);
      end
      if (notEmpty && !fwdRes1[16]) fwdRes1 = matchEntry(headEnt, fwd_addr1);
      if (notEmpty && !fwdRes2[16]) fwdRes2 = matchEntry(headEnt, fwd_addr2);
   end

   assign fwd_hit1  = fwdRes1[16];
   assign fwd_data1 = fwdRes1[15:0];
   assign fwd_hit2  = fwdRes2[16];
   assign fwd_data2 = fwdRes2[15:0];
`else
   logic unusedFwdAddr;
   assign unusedFwdAddr = ^{fwd_addr1, fwd_addr2};
   assign fwd_hit1  = 1'b0;
   assign fwd_hit2  = 1'b0;
   assign fwd_data1 = 16'h0000;
   assign fwd_data2 = 16'h0000;
`endif

endmodule

// File: tb/tb_writeback_ctrl.sv
// Testbench for writeback_ctrl: directed scenarios with a write scoreboard.
// Inputs change 1ns after the rising edge; outputs are sampled mid-cycle.
// Expected register-file writes are queued on accepted pushes and checked when RegWrt fires.
module tb_writeback_ctrl;

   typedef struct packed {
      logic        swp;
      logic [3:0]  dst;
      logic [3:0]  src;
      logic [15:0] dataA;
      logic [15:0] dataB;
   } expEnt_t;

`ifdef WB_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_swp = 1'b0;
   logic [3:0]  in_dst = 4'h0;
   logic [3:0]  in_src = 4'h0;
   logic [15:0] in_dataA = 16'h0;
   logic [15:0] in_dataB = 16'h0;
   logic        hold = 1'b0;
   logic        RegWrt, RegSwp;
   logic [3:0]  wrtRegOp1, swpReg1, swpReg2;
   logic [15:0] wrtDataOp1, wrtDataOp2;
   logic [3:0]  fwd_addr1 = 4'h0;
   logic [3:0]  fwd_addr2 = 4'h0;
   logic        fwd_hit1, fwd_hit2;
   logic [15:0] fwd_data1, fwd_data2;
   logic [1:0]  pending;

   int checks = 0;
   int errors = 0;
   expEnt_t expQ[$];

   writeback_ctrl dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_swp(in_swp), .in_dst(in_dst), .in_src(in_src),
      .in_dataA(in_dataA), .in_dataB(in_dataB),
      .hold(hold),
      .RegWrt(RegWrt), .RegSwp(RegSwp),
      .wrtRegOp1(wrtRegOp1), .swpReg1(swpReg1), .swpReg2(swpReg2),
      .wrtDataOp1(wrtDataOp1), .wrtDataOp2(wrtDataOp2),
      .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2),
      .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
      .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
      .pending(pending)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Scoreboard: a write retires at the next rising edge whenever RegWrt is high mid-cycle.
   always @(negedge clk) begin
      if (rst && RegWrt) begin
         checks++;
         if (expQ.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got dst=%0d dataA=%h, required no write", wrtRegOp1, wrtDataOp1);
         end else begin
            automatic expEnt_t e = expQ.pop_front();
            if (wrtRegOp1 !== e.dst || wrtDataOp1 !== e.dataA || RegSwp !== e.swp) begin
               errors++;
               $display("FAIL write_port: got swp=%b dst=%0d dataA=%h, required swp=%b dst=%0d dataA=%h",
                        RegSwp, wrtRegOp1, wrtDataOp1, e.swp, e.dst, e.dataA);
            end
            if (e.swp) begin
               checks++;
               if (swpReg1 !== e.dst || swpReg2 !== e.src || wrtDataOp2 !== e.dataB) begin
                  errors++;
                  $display("FAIL swap_port: got r1=%0d r2=%0d dataB=%h, required r1=%0d r2=%0d dataB=%h",
                           swpReg1, swpReg2, wrtDataOp2, e.dst, e.src, e.dataB);
               end
            end
         end
      end
   end

   // Presents one result for one cycle; queues the expected write only if accepted.
   task automatic pushEnt(input logic swp, input logic [3:0] dst, input logic [3:0] src,
                          input logic [15:0] dA, input logic [15:0] dB);
      in_valid = 1'b1; in_swp = swp; in_dst = dst; in_src = src; in_dataA = dA; in_dataB = dB;
      if (in_ready) expQ.push_back('{swp: swp, dst: dst, src: src, dataA: dA, dataB: dB});
      @(posedge clk); #1;
      in_valid = 1'b0; in_swp = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic checkDrained(input string name);
      checks++;
      if (pending !== 2'd0 || expQ.size() != 0) begin
         errors++;
         $display("FAIL %s_drained: got pending=%0d queued=%0d, required 0 and 0", name, pending, expQ.size());
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (pending !== 2'd0 || in_ready !== 1'b0 || RegWrt !== 1'b0 || RegSwp !== 1'b0 ||
          wrtRegOp1 !== 4'h0 || wrtDataOp1 !== 16'h0 || fwd_hit1 !== 1'b0 || fwd_data1 !== 16'h0) begin
         errors++;
         $display("FAIL reset_outputs: got pending=%0d rdy=%b wrt=%b swp=%b op1=%0d d1=%h hit=%b fd=%h, required all 0",
                  pending, in_ready, RegWrt, RegSwp, wrtRegOp1, wrtDataOp1, fwd_hit1, fwd_data1);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got in_ready=%b, required 1", in_ready);
      end
      cycles(1);
   endtask

   task automatic test_single_write();
      hold = 1'b0;
      pushEnt(1'b0, 4'd3, 4'd0, 16'h1234, 16'h0);
      checks++;
      if (RegWrt !== 1'b1 || RegSwp !== 1'b0 || wrtRegOp1 !== 4'd3 || wrtDataOp1 !== 16'h1234 || pending !== 2'd1) begin
         errors++;
         $display("FAIL single_write: got wrt=%b swp=%b op1=%0d d1=%h pend=%0d, required 1 0 3 1234 1",
                  RegWrt, RegSwp, wrtRegOp1, wrtDataOp1, pending);
      end
      cycles(1);
      checkDrained("single_write");
   endtask

   task automatic test_swap();
      hold = 1'b1;
      pushEnt(1'b1, 4'd4, 4'd5, 16'hAAAA, 16'h5555);
      fwd_addr1 = 4'd4; fwd_addr2 = 4'd5; #1;
      checks++;
      if (RegWrt !== 1'b0 || RegSwp !== 1'b0 || pending !== 2'd1) begin
         errors++;
         $display("FAIL swap_held: got wrt=%b swp=%b pend=%0d, required 0 0 1", RegWrt, RegSwp, pending);
      end
      checks++;
      if (fwd_hit1 !== FWD || fwd_data1 !== (FWD ? 16'h5555 : 16'h0) ||
          fwd_hit2 !== FWD || fwd_data2 !== (FWD ? 16'hAAAA : 16'h0)) begin
         errors++;
         $display("FAIL swap_forward: got h1=%b d1=%h h2=%b d2=%h, required h=%b d1=%h d2=%h",
                  fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, FWD, FWD ? 16'h5555 : 16'h0, FWD ? 16'hAAAA : 16'h0);
      end
      hold = 1'b0; #1;
      checks++;
      if (RegSwp !== 1'b1 || swpReg1 !== 4'd4 || swpReg2 !== 4'd5) begin
         errors++;
         $display("FAIL swap_strobe: got swp=%b r1=%0d r2=%0d, required 1 4 5", RegSwp, swpReg1, swpReg2);
      end
      cycles(1);
      checkDrained("swap");
   endtask

   task automatic test_full_hold();
      hold = 1'b1;
      pushEnt(1'b0, 4'd1, 4'd0, 16'h0101, 16'h0);
      pushEnt(1'b0, 4'd2, 4'd0, 16'h0202, 16'h0);
      checks++;
      if (pending !== 2'd2 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_state: got pend=%0d rdy=%b, required 2 0", pending, in_ready);
      end
      pushEnt(1'b0, 4'd3, 4'd0, 16'h0303, 16'h0);
      checks++;
      if (pending !== 2'd2 || wrtRegOp1 !== 4'd1) begin
         errors++;
         $display("FAIL full_refuse: got pend=%0d head=%0d, required 2 1", pending, wrtRegOp1);
      end
      hold = 1'b0; #1;
      checks++;
      if (RegWrt !== 1'b1 || wrtRegOp1 !== 4'd1) begin
         errors++;
         $display("FAIL full_first: got wrt=%b op1=%0d, required 1 1", RegWrt, wrtRegOp1);
      end
      cycles(1);
      checks++;
      if (RegWrt !== 1'b1 || wrtRegOp1 !== 4'd2 || pending !== 2'd1 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL full_second: got wrt=%b op1=%0d pend=%0d rdy=%b, required 1 2 1 1",
                  RegWrt, wrtRegOp1, pending, in_ready);
      end
      cycles(1);
      checkDrained("full_hold");
   endtask

   task automatic test_youngest();
      hold = 1'b1;
      pushEnt(1'b0, 4'd7, 4'd0, 16'h0001, 16'h0);
      pushEnt(1'b0, 4'd7, 4'd0, 16'h0002, 16'h0);
      fwd_addr1 = 4'd7; fwd_addr2 = 4'd8; #1;
      checks++;
      if (fwd_hit1 !== FWD || fwd_data1 !== (FWD ? 16'h0002 : 16'h0)) begin
         errors++;
         $display("FAIL youngest_wins: got hit=%b data=%h, required %b %h", fwd_hit1, fwd_data1, FWD, FWD ? 16'h0002 : 16'h0);
      end
      checks++;
      if (fwd_hit2 !== 1'b0 || fwd_data2 !== 16'h0) begin
         errors++;
         $display("FAIL no_match: got hit=%b data=%h, required 0 0000", fwd_hit2, fwd_data2);
      end
      // Incoming result must not be forwarded.
      in_valid = 1'b0; in_dst = 4'd8; in_dataA = 16'hBEEF; #1;
      checks++;
      if (fwd_hit2 !== 1'b0) begin
         errors++;
         $display("FAIL incoming_not_fwd: got hit=%b, required 0", fwd_hit2);
      end
      hold = 1'b0;
      cycles(2);
      checkDrained("youngest");
   endtask

   task automatic test_swap_same();
      hold = 1'b1;
      pushEnt(1'b1, 4'd9, 4'd9, 16'h1111, 16'h2222);
      fwd_addr1 = 4'd9; fwd_addr2 = 4'd9; #1;
      checks++;
      if (fwd_hit1 !== FWD || fwd_data1 !== (FWD ? 16'h2222 : 16'h0) || fwd_data2 !== fwd_data1) begin
         errors++;
         $display("FAIL swap_same: got hit=%b d1=%h d2=%h, required %b %h", fwd_hit1, fwd_data1, fwd_data2, FWD, FWD ? 16'h2222 : 16'h0);
      end
      hold = 1'b0;
      cycles(1);
      checkDrained("swap_same");
   endtask

   task automatic test_back_to_back();
      hold = 1'b0;
      pushEnt(1'b0, 4'd0, 4'd0, 16'hC000, 16'h0);
      pushEnt(1'b0, 4'd15, 4'd0, 16'hC00F, 16'h0);
      pushEnt(1'b1, 4'd0, 4'd15, 16'hD00D, 16'hE00E);
      checks++;
      if (pending !== 2'd1 || wrtRegOp1 !== 4'd0 || RegSwp !== 1'b1) begin
         errors++;
         $display("FAIL back_to_back: got pend=%0d op1=%0d swp=%b, required 1 0 1", pending, wrtRegOp1, RegSwp);
      end
      fwd_addr1 = 4'd0; fwd_addr2 = 4'd15; #1;
      checks++;
      if (fwd_data1 !== (FWD ? 16'hE00E : 16'h0) || fwd_data2 !== (FWD ? 16'hD00D : 16'h0)) begin
         errors++;
         $display("FAIL reg0_forward: got d1=%h d2=%h", fwd_data1, fwd_data2);
      end
      cycles(1);
      checkDrained("back_to_back");
   endtask

   task automatic test_reset_mid();
      hold = 1'b1;
      pushEnt(1'b0, 4'd6, 4'd0, 16'h6666, 16'h0);
      pushEnt(1'b0, 4'd11, 4'd0, 16'hBBBB, 16'h0);
      checks++;
      if (pending !== 2'd2) begin
         errors++;
         $display("FAIL reset_mid_fill: got pend=%0d, required 2", pending);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (pending !== 2'd0 || RegWrt !== 1'b0 || in_ready !== 1'b0 || wrtRegOp1 !== 4'h0) begin
         errors++;
         $display("FAIL reset_mid_async: got pend=%0d wrt=%b rdy=%b op1=%0d, required 0 0 0 0",
                  pending, RegWrt, in_ready, wrtRegOp1);
      end
      expQ.delete();
      hold = 1'b0;
      cycles(2);
      rst = 1'b1;
      cycles(3);
      checkDrained("reset_mid");
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_swap();
      test_full_hold();
      test_youngest();
      test_swap_same();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
